// File: rtl/regs_wb_ctrl_pkg.sv
// regs_wb_ctrl_pkg: shared core widths, write-back buffer depth default and entry type.
package regs_wb_ctrl_pkg;
    localparam int CPU_WIDTH          = 32;
    localparam int REG_ADDR_WIDTH     = 5;
    localparam int REG_DATA_DEPTH     = 1 << REG_ADDR_WIDTH;
    localparam int REGS_WB_FIFO_DEPTH = 4;

    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [CPU_WIDTH-1:0]      cpu_data_t;
    typedef logic [REG_DATA_DEPTH-1:0] reg_mask_t;

    typedef struct packed {
        reg_addr_t addr;
        cpu_data_t data;
    } wb_entry_t;

    localparam int WB_ENTRY_WIDTH = $bits(wb_entry_t);

    // x0 is hardwired, so it never appears in any scoreboard mask
    function automatic reg_mask_t addr_onehot(input logic en, input reg_addr_t a);
        return (en && a != '0) ? reg_mask_t'(1) << a : '0;
    endfunction
endpackage

// File: rtl/regs_wb_ctrl_if.sv
// regs_wb_ctrl_if: ALU/LSU write-back requests, register-file write port and busy scoreboard.
interface regs_wb_ctrl_if;
    import regs_wb_ctrl_pkg::*;

    logic      alu_wr_en_i;
    reg_addr_t alu_wr_adder_i;
    cpu_data_t alu_wr_data_i;
    logic      lsu_wr_valid_i;
    logic      lsu_wr_ready_o;
    reg_addr_t lsu_wr_adder_i;
    cpu_data_t lsu_wr_data_i;
    logic      lsu_issue_i;
    reg_addr_t lsu_issue_adder_i;
    logic      reg_wr_en_o;
    reg_addr_t reg_wr_adder_o;
    cpu_data_t reg_wr_data_o;
    reg_mask_t busy_o;

    modport master (
        output alu_wr_en_i, alu_wr_adder_i, alu_wr_data_i,
        output lsu_wr_valid_i, lsu_wr_adder_i, lsu_wr_data_i,
        output lsu_issue_i, lsu_issue_adder_i,
        input  lsu_wr_ready_o, reg_wr_en_o, reg_wr_adder_o, reg_wr_data_o, busy_o
    );

    modport slave (
        input  alu_wr_en_i, alu_wr_adder_i, alu_wr_data_i,
        input  lsu_wr_valid_i, lsu_wr_adder_i, lsu_wr_data_i,
        input  lsu_issue_i, lsu_issue_adder_i,
        output lsu_wr_ready_o, reg_wr_en_o, reg_wr_adder_o, reg_wr_data_o, busy_o
    );
endinterface

// File: rtl/regs_wb_fifo.sv
// regs_wb_fifo: synchronous in-order FIFO, power-of-two depth, push while full allowed when popping.
module regs_wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // pointers wrap through natural overflow because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/regs_wb_ctrl.sv
// regs_wb_ctrl: register-file write-back arbiter (ALU priority, buffered loads, pending-load scoreboard).
// Define REGS_WB_BYPASS_EN to let a load skip the empty buffer when the ALU is idle.
module regs_wb_ctrl
    import regs_wb_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = REGS_WB_FIFO_DEPTH
) (
    input logic           clk,
    input logic           rst,
    regs_wb_ctrl_if.slave bus
);
    wb_entry_t head;
    wb_entry_t lsu_entry;
    wb_entry_t alu_entry;
    wb_entry_t wr_next;
    logic      wr_en_next;
    logic      full;
    logic      empty;
    logic      pop;
    logic      push;
    logic      accept;
    logic      bypass;
    logic      lsu_nz;
    logic      alu_hit;
    reg_mask_t set_mask;
    reg_mask_t clr_mask;
    logic      wr_en_q;
    reg_addr_t wr_adder_q;
    cpu_data_t wr_data_q;
    reg_mask_t busy_q;

    assign lsu_entry = '{addr: bus.lsu_wr_adder_i, data: bus.lsu_wr_data_i};
    assign alu_entry = '{addr: bus.alu_wr_adder_i, data: bus.alu_wr_data_i};
    assign pop       = !bus.alu_wr_en_i && !empty;
    assign accept    = bus.lsu_wr_valid_i && bus.lsu_wr_ready_o;
    assign lsu_nz    = bus.lsu_wr_adder_i != '0;
    assign alu_hit   = bus.alu_wr_en_i && bus.alu_wr_adder_i != '0;

    assign bus.lsu_wr_ready_o = !full || pop;

`ifdef REGS_WB_BYPASS_EN
    assign bypass = accept && empty && !bus.alu_wr_en_i;
`else
    assign bypass = 1'b0;
`endif

    // x0 loads are acknowledged but never buffered
    assign push = accept && lsu_nz && !bypass;

    regs_wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WB_ENTRY_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (lsu_entry),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        wr_en_next = alu_hit || pop || (bypass && lsu_nz);
        wr_next    = bus.alu_wr_en_i ? alu_entry : pop ? head : lsu_entry;
        clr_mask   = addr_onehot(pop, head.addr) | addr_onehot(bypass, lsu_entry.addr);
        set_mask   = addr_onehot(bus.lsu_issue_i, bus.lsu_issue_adder_i);
    end

    // set is OR-ed after the clear so a re-issue in the emit cycle keeps the bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_q    <= 1'b0;
            wr_adder_q <= '0;
            wr_data_q  <= '0;
            busy_q     <= '0;
        end else begin
            wr_en_q <= wr_en_next;
            if (wr_en_next) begin
                wr_adder_q <= wr_next.addr;
                wr_data_q  <= wr_next.data;
            end
            busy_q <= (busy_q & ~clr_mask) | set_mask;
        end
    end

    assign bus.reg_wr_en_o    = wr_en_q;
    assign bus.reg_wr_adder_o = wr_adder_q;
    assign bus.reg_wr_data_o  = wr_data_q;
    assign bus.busy_o         = busy_q;

    alu_to_busy_a: assert property (@(posedge clk) disable iff (rst)
        !(bus.alu_wr_en_i && busy_q[bus.alu_wr_adder_i]));

    issue_to_busy_a: assert property (@(posedge clk) disable iff (rst)
        !(bus.lsu_issue_i && busy_q[bus.lsu_issue_adder_i] && !clr_mask[bus.lsu_issue_adder_i]));
endmodule

// File: tb/tb_regs_wb_ctrl.sv
// tb_regs_wb_ctrl: queue-based reference model feeding a scoreboard checked by an output monitor.
module tb_regs_wb_ctrl;
    import regs_wb_ctrl_pkg::*;

    localparam int FD = 4;

    typedef struct {
        reg_addr_t addr;
        cpu_data_t data;
        int        due;
    } exp_t;

    typedef struct {
        reg_addr_t addr;
        cpu_data_t data;
    } ld_t;

    logic      clk = 1'b0;
    logic      rst = 1'b0;
    int        cyc = 0;
    int        n_chk = 0;
    int        n_err = 0;
    exp_t      sb[$];
    ld_t       mq[$];
    reg_mask_t m_busy = '0;

    regs_wb_ctrl_if ifc();

    regs_wb_ctrl #(.FIFO_DEPTH(FD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic exp_t mk(input reg_addr_t a, input cpu_data_t d, input int due);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.due  = due;
        return e;
    endfunction

    function automatic ld_t mk_ld(input reg_addr_t a, input cpu_data_t d);
        ld_t e;
        e.addr = a;
        e.data = d;
        return e;
    endfunction

    // Reference: ALU first, then oldest buffered load, then (optionally) an unbuffered load; writes land next cycle.
    task automatic model(output logic acc);
        logic      room;
        logic      byp;
        reg_mask_t clr;
        reg_mask_t set_m;
        ld_t       e;
        room = mq.size() < FD || (!ifc.alu_wr_en_i && mq.size() != 0);
        chk("lsu_wr_ready", 64'(ifc.lsu_wr_ready_o), 64'(room));
        chk("busy", 64'(ifc.busy_o), 64'(m_busy));
        acc = ifc.lsu_wr_valid_i && room;
        byp = 1'b0;
`ifdef REGS_WB_BYPASS_EN
        byp = acc && mq.size() == 0 && !ifc.alu_wr_en_i;
`endif
        clr = '0;
        if (ifc.alu_wr_en_i) begin
            if (ifc.alu_wr_adder_i != 0) sb.push_back(mk(ifc.alu_wr_adder_i, ifc.alu_wr_data_i, cyc + 1));
        end else if (mq.size() != 0) begin
            e = mq.pop_front();
            sb.push_back(mk(e.addr, e.data, cyc + 1));
            clr[e.addr] = 1'b1;
        end else if (byp && ifc.lsu_wr_adder_i != 0) begin
            sb.push_back(mk(ifc.lsu_wr_adder_i, ifc.lsu_wr_data_i, cyc + 1));
            clr[ifc.lsu_wr_adder_i] = 1'b1;
        end
        if (acc && ifc.lsu_wr_adder_i != 0 && !byp) mq.push_back(mk_ld(ifc.lsu_wr_adder_i, ifc.lsu_wr_data_i));
        set_m = '0;
        if (ifc.lsu_issue_i && ifc.lsu_issue_adder_i != 0) set_m[ifc.lsu_issue_adder_i] = 1'b1;
        m_busy = (m_busy & ~clr) | set_m;
    endtask

    task automatic drive(input logic ae, input reg_addr_t aa, input cpu_data_t ad,
                         input logic lv, input reg_addr_t la, input cpu_data_t ld,
                         input logic iv, input reg_addr_t ia);
        ifc.alu_wr_en_i       = ae;
        ifc.alu_wr_adder_i    = aa;
        ifc.alu_wr_data_i     = ad;
        ifc.lsu_wr_valid_i    = lv;
        ifc.lsu_wr_adder_i    = la;
        ifc.lsu_wr_data_i     = ld;
        ifc.lsu_issue_i       = iv;
        ifc.lsu_issue_adder_i = ia;
    endtask

    task automatic tick(input logic ae, input reg_addr_t aa, input cpu_data_t ad,
                        input logic lv, input reg_addr_t la, input cpu_data_t ld,
                        input logic iv, input reg_addr_t ia, output logic acc);
        @(posedge clk);
        #1;
        drive(ae, aa, ad, lv, la, ld, iv, ia);
        #1;
        model(acc);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0, 0, 0, acc);
    endtask

    task automatic check_reset_outputs();
        chk("rst_wr_en", 64'(ifc.reg_wr_en_o), 64'd0);
        chk("rst_wr_adder", 64'(ifc.reg_wr_adder_o), 64'd0);
        chk("rst_wr_data", 64'(ifc.reg_wr_data_o), 64'd0);
        chk("rst_busy", 64'(ifc.busy_o), 64'd0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            while (sb.size() != 0 && sb[0].due < cyc) begin
                n_chk++;
                n_err++;
                $display("FAIL missing_write cycle %0d: no write seen, expected x%0d=%0h in cycle %0d",
                         cyc, sb[0].addr, sb[0].data, sb[0].due);
                void'(sb.pop_front());
            end
            if (ifc.reg_wr_en_o) begin
                if (sb.size() != 0 && sb[0].due == cyc) begin
                    e = sb.pop_front();
                    chk("wr_adder", 64'(ifc.reg_wr_adder_o), 64'(e.addr));
                    chk("wr_data", 64'(ifc.reg_wr_data_o), 64'(e.data));
                end else begin
                    n_chk++;
                    n_err++;
                    $display("FAIL spurious_write cycle %0d: got x%0d=%0h, expected no write",
                             cyc, ifc.reg_wr_adder_o, ifc.reg_wr_data_o);
                end
            end
        end
    end

    initial begin
        logic      acc;
        int        k;
        cpu_data_t ldat [5];
        reg_addr_t aa;
        reg_addr_t ia;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1 rst = 1'b1;
        #2 check_reset_outputs();
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;

        // single ALU write
        tick(1, 5, 32'h1234_5678, 0, 0, 0, 0, 0, acc);
        idle(3);

        // issued load: pending until its write-back
        tick(0, 0, 0, 0, 0, 0, 1, 7, acc);
        idle(1);
        tick(0, 0, 0, 1, 7, 32'hDEAD_BEEF, 0, 0, acc);
        chk("load_x7_accepted", 64'(acc), 64'd1);
        idle(4);

        // ALU hogs the port while loads pile up
        k = 0;
        for (int i = 0; i < 5; i++) ldat[i] = $urandom;
        for (int c = 0; c < 6; c++) begin
            tick(1, reg_addr_t'(c + 1), $urandom, k < 5, reg_addr_t'(16 + k), ldat[k % 5], 0, 0, acc);
            if (acc) k++;
        end
        chk("accepted_while_alu_busy", 64'(k), 64'd4);
        for (int c = 0; c < 10 && k < 5; c++) begin
            tick(0, 0, 0, 1, reg_addr_t'(16 + k), ldat[k], 0, 0, acc);
            if (acc) k++;
        end
        chk("all_loads_accepted", 64'(k), 64'd5);
        idle(8);

        // x0 writes from both sources are discarded
        tick(1, 0, 32'hFFFF_FFFF, 1, 0, $urandom, 0, 0, acc);
        chk("x0_load_ready", 64'(acc), 64'd1);
        tick(0, 0, 0, 1, 0, $urandom, 0, 0, acc);
        chk("x0_load_ready_idle", 64'(acc), 64'd1);
        idle(3);

        // re-issue in the emit cycle keeps the busy bit
        tick(0, 0, 0, 0, 0, 0, 1, 9, acc);
        idle(1);
`ifdef REGS_WB_BYPASS_EN
        tick(0, 0, 0, 1, 9, 32'h0000_0909, 1, 9, acc);
`else
        tick(0, 0, 0, 1, 9, 32'h0000_0909, 0, 0, acc);
        tick(0, 0, 0, 0, 0, 0, 1, 9, acc);
`endif
        idle(2);
        chk("busy9_held", 64'(ifc.busy_o[9]), 64'd1);
        tick(0, 0, 0, 1, 9, 32'h0000_0999, 0, 0, acc);
        idle(3);
        chk("busy9_cleared", 64'(ifc.busy_o[9]), 64'd0);

        // reset with buffered loads and pending registers
        tick(0, 0, 0, 0, 0, 0, 1, 5, acc);
        tick(0, 0, 0, 0, 0, 0, 1, 7, acc);
        for (int i = 0; i < 3; i++) tick(1, reg_addr_t'(1 + i), $urandom, 1, reg_addr_t'(20 + i), $urandom, 0, 0, acc);
        @(posedge clk);
        #1 drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("busy_before_rst", 64'(ifc.busy_o), 64'h0000_00A0);
        #2 rst = 1'b1;
        #1 check_reset_outputs();
        sb.delete();
        mq.delete();
        m_busy = '0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        idle(4);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            aa = reg_addr_t'($urandom);
            if (m_busy[aa]) aa = '0;
            ia = reg_addr_t'($urandom);
            if (m_busy[ia]) ia = '0;
            tick($urandom % 3 == 0, aa, $urandom,
                 $urandom % 2 == 0, reg_addr_t'($urandom), $urandom,
                 $urandom % 7 == 0, ia, acc);
        end
        idle(12);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/regs_wb_ctrl.md
REGS_WB_CTRL -- requirements
Module: regs_wb_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, load write-back buffer entries (power of 2, >=2).
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port alu_wr_en_i  input  1  ALU result write request; cannot be back-pressured.
REQ-005 SHALL have port alu_wr_adder_i  input  REG_ADDR_WIDTH  ALU destination register.
REQ-006 SHALL have port alu_wr_data_i  input  CPU_WIDTH  ALU result.
REQ-007 SHALL have port lsu_wr_valid_i  input  1  load data valid.
REQ-008 SHALL have port lsu_wr_ready_o  output  1  load data accepted when valid&ready.
REQ-009 SHALL have port lsu_wr_adder_i  input  REG_ADDR_WIDTH  load destination register.
REQ-010 SHALL have port lsu_wr_data_i  input  CPU_WIDTH  load data.
REQ-011 SHALL have port lsu_issue_i  input  1  load issued; marks destination pending.
REQ-012 SHALL have port lsu_issue_adder_i  input  REG_ADDR_WIDTH  destination of issued load.
REQ-013 SHALL have port reg_wr_en_o  output  1  register-file write enable.
REQ-014 SHALL have port reg_wr_adder_o  output  REG_ADDR_WIDTH  register-file write address.
REQ-015 SHALL have port reg_wr_data_o  output  CPU_WIDTH  register-file write data.
REQ-016 SHALL have port busy_o  output  REG_DATA_DEPTH  per-register pending-load scoreboard.

Function
REQ-017 SHALL register all reg_wr_* outputs; ALU write sampled at edge N appears on reg_wr_* during cycle N+1 for one cycle.
REQ-018 SHALL push accepted load writes into an in-order FIFO; an entry pushed at edge N is eligible for output no earlier than cycle N+2.
REQ-019 SHALL give the ALU strict priority; the FIFO head pops only in cycles with alu_wr_en_i low.
REQ-020 SHALL drive lsu_wr_ready_o = !full | pop-this-cycle (simultaneous push and pop when full allowed).
REQ-021 SHALL push and pop in the same cycle on a non-full, non-empty FIFO with count unchanged; wrap pointers modulo FIFO_DEPTH.
REQ-022 SHALL drop writes to address 0 from either source: no reg_wr_en_o pulse, FIFO not pushed, ready still asserted.
REQ-023 SHALL set busy_o[a] at the edge after lsu_issue_i with adder a (a!=0); busy_o[0] is constant 0.
REQ-024 SHALL clear busy_o[a] at the edge where the load write to a is emitted on reg_wr_* (or dropped for a=0).
REQ-025 SHALL let set win over clear when both target the same address in one cycle.
REQ-026 SHALL treat ALU write to a busy address, or lsu_issue_i to a busy address, as protocol violation (simulation assertion; no RTL recovery).
REQ-027 SHALL emit at most one write per cycle.

Reset
REQ-028 SHALL, on rst asserted, asynchronously clear reg_wr_en_o, reg_wr_adder_o, reg_wr_data_o, busy_o, FIFO pointers and count; lsu_wr_ready_o=1 once rst deasserts.
REQ-029 SHALL discard in-flight FIFO contents on reset mid-operation; no write emitted in first cycle after release.

Configuration
REQ-030 SHALL honour macro REGS_WB_BYPASS_EN: defined -> with FIFO empty and alu_wr_en_i low, an accepted load write bypasses the FIFO and appears on reg_wr_* in cycle N+1; undefined -> all load writes go through the FIFO (REQ-018 latency).

Structure
REQ-031 SHALL take CPU_WIDTH, REG_ADDR_WIDTH, REG_DATA_DEPTH from the shared rooth_defines file; add REGS_WB_FIFO_DEPTH default there.
REQ-032 SHALL instantiate one sub-module regs_wb_fifo (synchronous FIFO, parameterised depth/width, push/pop/full/empty).

Verification
REQ-033 SHALL cover: ALU write x5=0x1234_5678 at cycle 0 -> reg_wr_en_o=1, adder 5, data 0x12345678 in cycle 1 only.
REQ-034 SHALL cover: lsu_issue x7, then load x7=0xDEAD_BEEF with ALU idle -> busy_o[7]=1 until emit; emit cycle N+2 (N+1 with REGS_WB_BYPASS_EN); busy_o[7]=0 after.
REQ-035 SHALL cover: ALU busy 6 consecutive cycles while 5 loads offered, FIFO_DEPTH=4 -> ready low after 4 accepted; loads drain in order once ALU idles; none lost.
REQ-036 SHALL cover: ALU write x0=0xFFFF_FFFF and load x0 -> no reg_wr_en_o pulse; busy_o[0] stays 0.
REQ-037 SHALL cover: rst pulsed with 3 FIFO entries and busy_o=0x0000_00A0 -> all outputs 0, busy_o=0, no write after release.
REQ-038 SHALL cover: lsu_issue x9 in same cycle as pending x9 load emits -> busy_o[9] remains 1.
